// File: rtl/synapse_accumulator_if.sv
// Bus between a spike/weight source and the synapse accumulator stage.
// The master side drives the control, spike and weight-write signals; the slave returns the current sample and status.
interface synapse_accumulator_if #(
    parameter int N_INPUTS     = 8,
    parameter int WEIGHT_WIDTH = 8,
    parameter int OUT_WIDTH    = 8
);
    localparam int AW = $clog2(N_INPUTS);

    logic                           enable;
    logic                           tick;
    logic [N_INPUTS-1:0]            spikes_in;
    logic                           w_we;
    logic [AW-1:0]                  w_addr;
    logic signed [WEIGHT_WIDTH-1:0] w_data;
    logic [OUT_WIDTH-1:0]           i_current;
    logic                           i_valid;
    logic                           busy;
    logic                           tick_drop;

    modport master (
        output enable, tick, spikes_in, w_we, w_addr, w_data,
        input  i_current, i_valid, busy, tick_drop
    );

    modport slave (
        input  enable, tick, spikes_in, w_we, w_addr, w_data,
        output i_current, i_valid, busy, tick_drop
    );
endinterface

// File: rtl/synapse_accumulator.sv
// Serial synapse MAC for one LIF neuron: on each tick it scans the latched spike vector one input per clock.
// It then emits a saturated unsigned current sample with a one-cycle valid strobe.
module synapse_accumulator #(
    parameter int N_INPUTS     = 8,
    parameter int WEIGHT_WIDTH = 8,
    parameter int ACC_WIDTH    = 12,
    parameter int OUT_WIDTH    = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    synapse_accumulator_if.slave  bus
);
    localparam int AW = $clog2(N_INPUTS);
    localparam logic [AW-1:0] IDX_LAST = AW'(N_INPUTS - 1);
    localparam logic signed [ACC_WIDTH-1:0] OUT_MAX = ACC_WIDTH'((1 << OUT_WIDTH) - 1);

    typedef enum logic [1:0] {IDLE, SCAN, EMIT} state_e;

    state_e                         state_q, state_d;
    logic [AW-1:0]                  idx_q, idx_d;
    logic signed [ACC_WIDTH-1:0]    acc_q, acc_d;
    logic [N_INPUTS-1:0]            spk_q, spk_d;
    logic [OUT_WIDTH-1:0]           cur_q, cur_d;
    logic                           valid_q, valid_d;
    logic                           busy_q, busy_d;
    logic                           drop_q, drop_d;
    logic signed [WEIGHT_WIDTH-1:0] w_q [N_INPUTS];
    logic signed [WEIGHT_WIDTH-1:0] w_d [N_INPUTS];
    logic signed [ACC_WIDTH-1:0]    w_ext;

    // The MAC reads the registered weight, so a write landing this cycle is only seen next cycle.
    assign w_ext = {{(ACC_WIDTH-WEIGHT_WIDTH){w_q[idx_q][WEIGHT_WIDTH-1]}}, w_q[idx_q]};

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        acc_d   = acc_q;
        spk_d   = spk_q;
        cur_d   = cur_q;
        valid_d = 1'b0;
        drop_d  = 1'b0;
        w_d     = w_q;

        if (bus.w_we && (int'(bus.w_addr) < N_INPUTS))
            w_d[bus.w_addr] = bus.w_data;

        if (!bus.enable) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.tick) begin
                        spk_d   = bus.spikes_in;
                        acc_d   = '0;
                        idx_d   = '0;
                        state_d = SCAN;
                    end
                end
                SCAN: begin
                    drop_d = bus.tick;
                    if (spk_q[idx_q])
                        acc_d = acc_q + w_ext;
                    if (idx_q == IDX_LAST)
                        state_d = EMIT;
                    else
                        idx_d = idx_q + 1'b1;
                end
                EMIT: begin
                    drop_d  = bus.tick;
                    valid_d = 1'b1;
                    state_d = IDLE;
                    if (acc_q[ACC_WIDTH-1])
                        cur_d = '0;
                    else if (acc_q > OUT_MAX)
                        cur_d = '1;
                    else
                        cur_d = acc_q[OUT_WIDTH-1:0];
                end
                default: state_d = IDLE;
            endcase
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            acc_q   <= '0;
            spk_q   <= '0;
            cur_q   <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            drop_q  <= 1'b0;
            w_q     <= '{default: '0};
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            acc_q   <= acc_d;
            spk_q   <= spk_d;
            cur_q   <= cur_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            drop_q  <= drop_d;
            w_q     <= w_d;
        end
    end

    assign bus.i_current = cur_q;
    assign bus.i_valid   = valid_q;
    assign bus.busy      = busy_q;
    assign bus.tick_drop = drop_q;
endmodule

// File: tb/tb_synapse_accumulator.sv
// Scoreboard bench for synapse_accumulator: stimulus pushes expected current and strobe cycle,
// a negedge monitor pops and compares whenever i_valid is seen.
module tb_synapse_accumulator;
    localparam int N  = 8;
    localparam int WW = 8;
    localparam int AW = 3;
    localparam int OW = 8;

    typedef struct {
        int val;
        int due;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    synapse_accumulator_if #(.N_INPUTS(N), .WEIGHT_WIDTH(WW), .OUT_WIDTH(OW)) bus();

    synapse_accumulator #(.N_INPUTS(N), .WEIGHT_WIDTH(WW), .ACC_WIDTH(12), .OUT_WIDTH(OW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    exp_t sbq[$];
    exp_t mon_e;
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;
    int   wm[N];
    int   last_cur = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst_n && bus.i_valid) begin
            checks++;
            if (sbq.size() == 0) begin
                errors++;
                $display("FAIL unexpected_valid: got strobe with i_current=%0d at cycle %0d, required no strobe",
                         bus.i_current, cyc);
            end else begin
                mon_e = sbq.pop_front();
                if (int'(bus.i_current) != mon_e.val || cyc != mon_e.due) begin
                    errors++;
                    $display("FAIL scoreboard: got i_current=%0d at cycle %0d, required %0d at cycle %0d",
                             bus.i_current, cyc, mon_e.val, mon_e.due);
                end
            end
        end else if (sbq.size() > 0 && cyc > sbq[0].due) begin
            checks++;
            errors++;
            $display("FAIL missed_valid: got no strobe by cycle %0d, required i_current=%0d at cycle %0d",
                     cyc, sbq[0].val, sbq[0].due);
            void'(sbq.pop_front());
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    task automatic wr(input int a, input int d);
        bus.w_we   = 1'b1;
        bus.w_addr = AW'(a);
        bus.w_data = WW'(d);
        step();
        bus.w_we   = 1'b0;
        wm[a]      = d;
    endtask

    task automatic wait_done();
        for (int k = 0; k < 40 && sbq.size() > 0; k++) step();
        if (sbq.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL timeout: got %0d pending strobes, required 0", sbq.size());
            sbq.delete();
        end
    endtask

    // Input i is summed during the cycle after edge T+i, so a write landing at edge T+off
    // is seen only by indices i >= off.
    function automatic int model(input logic [N-1:0] spk, input int off, input bit do_wr,
                                 input int wa, input int wd);
        int s;
        s = 0;
        for (int i = 0; i < N; i++)
            if (spk[i]) s += (do_wr && i == wa && i >= off) ? wd : wm[i];
        if (s < 0) s = 0;
        if (s > (1 << OW) - 1) s = (1 << OW) - 1;
        return s;
    endfunction

    task automatic run_scan(input logic [N-1:0] spk, input int off, input bit do_wr,
                            input int wa, input int wd);
        int e;
        e = model(spk, off, do_wr, wa, wd);
        bus.tick      = 1'b1;
        bus.spikes_in = spk;
        step();
        bus.tick = 1'b0;
        sbq.push_back('{e, cyc + N + 1});
        check("busy_after_tick", int'(bus.busy), 1);
        for (int j = 1; j <= off; j++) begin
            if (do_wr && j == off) begin
                bus.w_we   = 1'b1;
                bus.w_addr = AW'(wa);
                bus.w_data = WW'(wd);
            end
            step();
            bus.w_we = 1'b0;
        end
        if (do_wr) wm[wa] = wd;
        wait_done();
        last_cur = e;
    endtask

    initial begin
        bus.enable    = 1'b1;
        bus.tick      = 1'b0;
        bus.spikes_in = '0;
        bus.w_we      = 1'b0;
        bus.w_addr    = '0;
        bus.w_data    = '0;
        for (int i = 0; i < N; i++) wm[i] = 0;
        step();
        step();
        rst_n = 1'b1;
        step();
        check("reset_i_current", int'(bus.i_current), 0);
        check("reset_i_valid", int'(bus.i_valid), 0);
        check("reset_busy", int'(bus.busy), 0);
        check("reset_tick_drop", int'(bus.tick_drop), 0);

        // basic sum, then upper saturation
        for (int i = 0; i < N; i++) wr(i, 10);
        run_scan(8'hFF, 1, 1'b0, 0, 0);
        for (int i = 0; i < N; i++) wr(i, 100);
        run_scan(8'hFF, 1, 1'b0, 0, 0);

        // negative clamp, then single input
        wr(0, -128);
        wr(1, 20);
        run_scan(8'h03, 1, 1'b0, 0, 0);
        run_scan(8'h02, 1, 1'b0, 0, 0);

        // tick while busy is dropped; tick on the strobe cycle is accepted
        for (int i = 0; i < N; i++) wr(i, 10);
        bus.tick      = 1'b1;
        bus.spikes_in = 8'hFF;
        step();
        bus.tick = 1'b0;
        sbq.push_back('{80, cyc + N + 1});
        step(); step(); step();
        bus.tick      = 1'b1;
        bus.spikes_in = 8'h01;
        step();
        bus.tick = 1'b0;
        check("tick_drop_pulse", int'(bus.tick_drop), 1);
        step();
        check("tick_drop_clear", int'(bus.tick_drop), 0);
        for (int k = 0; k < 20 && !bus.i_valid; k++) step();
        check("valid_seen", int'(bus.i_valid), 1);
        bus.tick      = 1'b1;
        bus.spikes_in = 8'h0F;
        step();
        bus.tick = 1'b0;
        sbq.push_back('{40, cyc + N + 1});
        check("b2b_no_drop", int'(bus.tick_drop), 0);
        check("b2b_busy", int'(bus.busy), 1);
        wait_done();
        last_cur = 40;

        // mid-scan write seen ahead of the scan; same-cycle write uses the old weight
        wr(7, 0);
        run_scan(8'h80, 3, 1'b1, 7, 50);
        wr(4, 33);
        run_scan(8'h10, 5, 1'b1, 4, 77);
        run_scan(8'h10, 1, 1'b0, 0, 0);

        // randomized weights, spikes and mid-scan writes
        for (int it = 0; it < 25; it++) begin
            int nw;
            nw = $urandom_range(0, 3);
            for (int k = 0; k < nw; k++)
                wr($urandom_range(0, N - 1), $urandom_range(0, 255) - 128);
            run_scan(N'($urandom), $urandom_range(1, N + 1), 1'($urandom),
                     $urandom_range(0, N - 1), $urandom_range(0, 255) - 128);
        end

        // enable drop mid-scan aborts without a strobe
        bus.tick      = 1'b1;
        bus.spikes_in = 8'hFF;
        step();
        bus.tick = 1'b0;
        step(); step(); step();
        bus.enable = 1'b0;
        step();
        check("abort_busy", int'(bus.busy), 0);
        check("abort_hold_cur", int'(bus.i_current), last_cur);
        bus.tick = 1'b1;
        step();
        bus.tick = 1'b0;
        check("disabled_no_drop", int'(bus.tick_drop), 0);
        check("disabled_not_busy", int'(bus.busy), 0);
        for (int k = 0; k < 12; k++) step();
        bus.enable = 1'b1;

        // asynchronous reset mid-scan clears outputs and weights
        for (int i = 0; i < N; i++) wr(i, 20);
        bus.tick      = 1'b1;
        bus.spikes_in = 8'hFF;
        step();
        bus.tick = 1'b0;
        step(); step(); step();
        rst_n = 1'b0;
        #1;
        check("rst_i_current", int'(bus.i_current), 0);
        check("rst_busy", int'(bus.busy), 0);
        check("rst_i_valid", int'(bus.i_valid), 0);
        for (int i = 0; i < N; i++) wm[i] = 0;
        step();
        rst_n = 1'b1;
        step();
        run_scan(8'hFF, 1, 1'b0, 0, 0);

        step(); step();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
